hood_mode_ctrl: RTL



---
 rtl/hood_mode_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/hood_mode_ctrl.sv
// Range-hood mode sequencer: button pulses to registered mode code, one-shot gear-3 timer,
// optional timed self-clean (compiled in when HOOD_SELF_CLEAN_EN is defined).
module hood_mode_ctrl #(
  parameter int unsigned HURRI_MIN = 1,
  parameter int unsigned HURRI_SEC = 0,
  parameter int unsigned CLEAN_MIN = 3,
  parameter int unsigned CLEAN_SEC = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       power_btn,
  input  logic       menu_btn,
  input  logic       gear1_btn,
  input  logic       gear2_btn,
  input  logic       gear3_btn,
  input  logic       clean_btn,
  output logic [2:0] mode_state,
  output logic [5:0] remain_min,
  output logic [5:0] remain_sec,
  output logic       hurricane_avail,
  output logic       exit_armed,
  output logic       clean_done
);

  localparam logic [2:0] S_STANDBY = 3'b000;
  localparam logic [2:0] S_G1      = 3'b001;
  localparam logic [2:0] S_G2      = 3'b010;
  localparam logic [2:0] S_G3      = 3'b011;
  localparam logic [2:0] S_CLEAN   = 3'b100;
  localparam logic [2:0] S_OFF     = 3'b111;

  localparam logic [5:0] HURRI_MIN_C = 6'(HURRI_MIN);
  localparam logic [5:0] HURRI_SEC_C = 6'(HURRI_SEC);

  logic [2:0] state_q, state_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       avail_q, avail_d;
  logic       armed_q, armed_d;
  logic       done_q, done_d;

  logic       expire_s;
  logic [5:0] dec_min_s;
  logic [5:0] dec_sec_s;
  logic       clean_req_s;

`ifdef HOOD_SELF_CLEAN_EN
  localparam logic [5:0] CLEAN_MIN_C = 6'(CLEAN_MIN);
  localparam logic [5:0] CLEAN_SEC_C = 6'(CLEAN_SEC);
  assign clean_req_s = clean_btn;
`else
  // Without self-clean the button and its timing parameters have no effect.
  logic clean_unused_s;
  assign clean_unused_s = clean_btn ^ (CLEAN_MIN != 0) ^ (CLEAN_SEC != 0);
  assign clean_req_s    = 1'b0;
`endif

  // A tick at 00:01 (or at 00:00 for a zero-length load) ends the timed mode.
  assign expire_s  = (min_q == 6'd0) && (sec_q <= 6'd1);
  assign dec_min_s = ((sec_q == 6'd0) && (min_q != 6'd0)) ? (min_q - 6'd1) : min_q;
  assign dec_sec_s = ((sec_q == 6'd0) && (min_q != 6'd0)) ? 6'd59 : (sec_q - 6'd1);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    avail_d = avail_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    case (state_q)
      S_OFF: begin
        if (power_btn) begin
          state_d = S_STANDBY;
          avail_d = 1'b1;
        end else begin
          state_d = S_OFF;
        end
      end
      S_STANDBY, S_G1, S_G2: begin
        if (power_btn && (state_q == S_STANDBY)) begin
          state_d = S_OFF;
        end else if (menu_btn && (state_q != S_STANDBY)) begin
          state_d = S_STANDBY;
`ifdef HOOD_SELF_CLEAN_EN
        end else if (clean_req_s && (state_q == S_STANDBY)) begin
          state_d = S_CLEAN;
          min_d   = CLEAN_MIN_C;
          sec_d   = CLEAN_SEC_C;
`endif
        end else if (gear3_btn && avail_q) begin
          state_d = S_G3;
          min_d   = HURRI_MIN_C;
          sec_d   = HURRI_SEC_C;
          avail_d = 1'b0;
          armed_d = 1'b0;
        end else if (gear2_btn && (state_q != S_G2)) begin
          state_d = S_G2;
        end else if (gear1_btn && (state_q != S_G1)) begin
          state_d = S_G1;
        end else begin
          state_d = state_q;
        end
      end
      S_G3: begin
        // A menu press in the expiring cycle still counts towards the exit.
        armed_d = armed_q | menu_btn;
        if (tick_1hz) begin
          if (expire_s) begin
            state_d = (armed_q | menu_btn) ? S_STANDBY : S_G2;
            min_d   = 6'd0;
            sec_d   = 6'd0;
            armed_d = 1'b0;
          end else begin
            min_d = dec_min_s;
            sec_d = dec_sec_s;
          end
        end else begin
          state_d = S_G3;
        end
      end
`ifdef HOOD_SELF_CLEAN_EN
      S_CLEAN: begin
        if (menu_btn) begin
          state_d = S_STANDBY;
          min_d   = 6'd0;
          sec_d   = 6'd0;
        end else if (tick_1hz) begin
          if (expire_s) begin
            state_d = S_STANDBY;
            min_d   = 6'd0;
            sec_d   = 6'd0;
            done_d  = 1'b1;
          end else begin
            min_d = dec_min_s;
            sec_d = dec_sec_s;
          end
        end else begin
          state_d = S_CLEAN;
        end
      end
`endif
      default: begin
        state_d = S_OFF;
        min_d   = 6'd0;
        sec_d   = 6'd0;
        avail_d = 1'b0;
        armed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      avail_q <= 1'b0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      avail_q <= avail_d;
      armed_q <= armed_d;
      done_q  <= done_d;
    end
  end

  assign mode_state      = state_q;
  assign remain_min      = min_q;
  assign remain_sec      = sec_q;
  assign hurricane_avail = avail_q;
  assign exit_armed      = armed_q;
  assign clean_done      = done_q;

endmodule
